// File: rtl/bus_stim_gen.sv
// bus_stim_gen: sequences one request per bus master after a start edge.
// Slave busy lines are held high for the whole sequence and dropped on a
// release edge. Each master gets a one-cycle ready pulse, then a bounded wait
// for its done pulse, then an idle gap. The release input is named
// release_req because "release" is a reserved word.
module bus_stim_gen #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int DATA_W      = 8,
    parameter int GAP_CYCLES  = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          release_req,
    input  logic [NUM_MASTERS-1:0]        rw_mask,
    input  logic [NUM_MASTERS-1:0]        m_done,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic [NUM_MASTERS-1:0]        m_rw,
    output logic [NUM_SLAVES-1:0]         s_busy,
    output logic [DATA_W-1:0]             last_rdata,
    output logic [7:0]                    txn_count,
    output logic                          timeout_flag,
    output logic [7:0]                    led
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        GAP   = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t                   state, state_nxt;
    logic [IDX_W-1:0]         idx, idx_nxt;
    logic [7:0]               wcnt, wcnt_nxt;
    logic [7:0]               gcnt, gcnt_nxt;
    logic                     start_q, release_q;
    logic                     start_edge, release_edge;
    logic [NUM_MASTERS-1:0]   ready_nxt, rw_nxt;
    logic [NUM_SLAVES-1:0]    busy_nxt;
    logic [DATA_W-1:0]        rdata_nxt;
    logic [7:0]               cnt_nxt;
    logic                     tf_nxt;

    assign start_edge   = start & ~start_q;
    assign release_edge = release_req & ~release_q;

    // Status display built purely from registered state.
    assign led = {state, timeout_flag, txn_count[3:0]};

    // State register, edge-detect history and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            wcnt         <= '0;
            gcnt         <= '0;
            start_q      <= 1'b0;
            release_q    <= 1'b0;
            m_ready      <= '0;
            m_rw         <= '0;
            s_busy       <= '1;
            last_rdata   <= '0;
            txn_count    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            wcnt         <= wcnt_nxt;
            gcnt         <= gcnt_nxt;
            start_q      <= start;
            release_q    <= release_req;
            m_ready      <= ready_nxt;
            m_rw         <= rw_nxt;
            s_busy       <= busy_nxt;
            last_rdata   <= rdata_nxt;
            txn_count    <= cnt_nxt;
            timeout_flag <= tf_nxt;
        end
    end

    // Next-state and next-output decode; every register holds unless changed.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wcnt_nxt  = wcnt;
        gcnt_nxt  = gcnt;
        ready_nxt = '0;
        rw_nxt    = m_rw;
        busy_nxt  = s_busy;
        rdata_nxt = last_rdata;
        cnt_nxt   = txn_count;
        tf_nxt    = timeout_flag;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    idx_nxt   = '0;
                    busy_nxt  = '1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                ready_nxt[idx] = 1'b1;
                rw_nxt[idx]    = rw_mask[idx];
                wcnt_nxt       = '0;
                state_nxt      = WAIT;
            end
            WAIT: begin
                if (m_done[idx]) begin
                    rdata_nxt = m_rdata[idx*DATA_W +: DATA_W];
                    if (txn_count != 8'hFF)
                        cnt_nxt = txn_count + 8'd1;
                    gcnt_nxt  = '0;
                    state_nxt = GAP;
                end else if (wcnt == 8'(TIMEOUT - 1)) begin
                    tf_nxt    = 1'b1;
                    gcnt_nxt  = '0;
                    state_nxt = GAP;
                end else begin
                    wcnt_nxt = wcnt + 8'd1;
                end
            end
            GAP: begin
                // A zero-length gap still spends one transit cycle here.
                if ((32'(gcnt) + 32'd1) >= 32'(GAP_CYCLES)) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = HOLD;
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = ISSUE;
                    end
                end else begin
                    gcnt_nxt = gcnt + 8'd1;
                end
            end
            HOLD: begin
                if (release_edge) begin
                    busy_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_stim_gen.sv
// Directed bench for bus_stim_gen. Stimulus tasks keep a transaction-level
// expectation of every output; a negedge process compares it each cycle.
module tb_bus_stim_gen;

    localparam int NM = 2;
    localparam int NS = 3;
    localparam int DW = 8;
    localparam int GC = 1;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              rst, start, release_req;
    logic [NM-1:0]     rw_mask, m_done;
    logic [NM*DW-1:0]  m_rdata;
    logic [NM-1:0]     m_ready, m_rw;
    logic [NS-1:0]     s_busy;
    logic [DW-1:0]     last_rdata;
    logic [7:0]        txn_count;
    logic              timeout_flag;
    logic [7:0]        led;

    // Expected view of the outputs after the most recent clock edge.
    logic [NM-1:0]     exp_ready, exp_rw;
    logic [NS-1:0]     exp_busy;
    logic [DW-1:0]     exp_rdata;
    int                exp_cnt;
    logic              exp_tf;
    int                exp_state;
    bit                model_on = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bus_stim_gen #(
        .NUM_MASTERS(NM),
        .NUM_SLAVES (NS),
        .DATA_W     (DW),
        .GAP_CYCLES (GC),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .release_req (release_req),
        .rw_mask     (rw_mask),
        .m_done      (m_done),
        .m_rdata     (m_rdata),
        .m_ready     (m_ready),
        .m_rw        (m_rw),
        .s_busy      (s_busy),
        .last_rdata  (last_rdata),
        .txn_count   (txn_count),
        .timeout_flag(timeout_flag),
        .led         (led)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Per-cycle comparison of every output against the expectation.
    always @(negedge clk) begin
        if (model_on) begin
            cmp("m_ready",      32'(m_ready),      32'(exp_ready));
            cmp("m_rw",         32'(m_rw),         32'(exp_rw));
            cmp("s_busy",       32'(s_busy),       32'(exp_busy));
            cmp("last_rdata",   32'(last_rdata),   32'(exp_rdata));
            cmp("txn_count",    32'(txn_count),    exp_cnt);
            cmp("timeout_flag", 32'(timeout_flag), 32'(exp_tf));
            cmp("led",          32'(led),          {24'b0, 3'(exp_state), exp_tf, 4'(exp_cnt)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_ready = '0;
    endtask

    task automatic exp_reset();
        exp_ready = '0;
        exp_rw    = '0;
        exp_busy  = '1;
        exp_rdata = '0;
        exp_cnt   = 0;
        exp_tf    = 1'b0;
        exp_state = 0;
    endtask

    // One full sequence. dly<0 withholds done (timeout); inj adds ignored
    // stimulus: release edge in ISSUE, start edge and foreign done in WAIT,
    // all done bits high in GAP.
    task automatic run_seq(input logic [NM-1:0] mask, input int d0, input int d1,
                           input logic [DW-1:0] r0, input logic [DW-1:0] r1, input bit inj);
        int            dly;
        logic [DW-1:0] rd;
        logic [NM-1:0] mine;
        start   = 1'b1;
        rw_mask = mask;
        tick();
        exp_state = 1;
        exp_busy  = '1;
        start = 1'b0;
        for (int m = 0; m < NM; m++) begin
            dly  = (m == 0) ? d0 : d1;
            rd   = (m == 0) ? r0 : r1;
            mine = NM'(1) << m;
            if (inj && m == 0) release_req = 1'b1;
            tick();
            exp_ready[m] = 1'b1;
            exp_rw[m]    = mask[m];
            exp_state    = 2;
            release_req  = 1'b0;
            for (int k = 0; k < ((dly < 0) ? TO : dly); k++) begin
                start  = inj && (k == 0);
                m_done = inj ? ~mine : '0;
                tick();
                if (dly < 0 && k == TO - 1) begin
                    exp_tf    = 1'b1;
                    exp_state = 3;
                end
            end
            start = 1'b0;
            if (dly >= 0) begin
                m_done  = mine;
                m_rdata = NM*DW'({$urandom, $urandom});
                m_rdata[m*DW +: DW] = rd;
                tick();
                exp_rdata = rd;
                exp_cnt   = (exp_cnt < 255) ? exp_cnt + 1 : 255;
                exp_state = 3;
            end
            m_done = inj ? '1 : '0;
            tick();
            exp_state = (m == NM - 1) ? 4 : 1;
            m_done = '0;
        end
        tick();
        release_req = 1'b1;
        tick();
        exp_busy    = '0;
        exp_state   = 0;
        release_req = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        release_req = 1'b0;
        rw_mask     = '0;
        m_done      = '0;
        m_rdata     = '0;
        tick();
        exp_reset();
        model_on = 1'b1;
        cmp("reset_busy", 32'(s_busy), 32'h7);
        cmp("reset_led",  32'(led),    32'h00);
        rst = 1'b0;
        tick();
        tick();

        // Basic sequence: master 0 writes-select 1, master 1 select 0.
        run_seq(2'b01, 1, 0, 8'hA5, 8'h3C, 1'b0);
        cmp("seq1_led",   32'(led),        32'h02);
        cmp("seq1_rdata", 32'(last_rdata), 32'h3C);
        cmp("seq1_rw",    32'(m_rw),       32'h1);
        cmp("seq1_busy",  32'(s_busy),     32'h0);
        tick();

        // Master 0 times out, master 1 completes.
        run_seq(2'b10, -1, 3, 8'h11, 8'h22, 1'b0);
        cmp("to_flag",  32'(timeout_flag), 32'h1);
        cmp("to_count", 32'(txn_count),    32'd3);
        cmp("to_led",   32'(led),          32'h13);
        cmp("to_rw",    32'(m_rw),         32'h2);

        // Ignored start/release/done activity.
        run_seq(2'b11, 2, 1, 8'h5A, 8'hC3, 1'b1);
        cmp("inj_count", 32'(txn_count),  32'd5);
        cmp("inj_rdata", 32'(last_rdata), 32'hC3);

        // Reset in WAIT with start held high across reset deassertion.
        start   = 1'b1;
        rw_mask = 2'b00;
        tick();
        exp_state = 1;
        exp_busy  = '1;
        start = 1'b0;
        tick();
        exp_ready[0] = 1'b1;
        exp_rw[0]    = 1'b0;
        exp_state    = 2;
        tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        exp_reset();
        cmp("rst_flag",  32'(timeout_flag), 32'h0);
        cmp("rst_count", 32'(txn_count),    32'd0);
        cmp("rst_led",   32'(led),          32'h00);
        rst = 1'b0;
        run_seq(2'b10, 0, 0, 8'h77, 8'h88, 1'b0);
        cmp("post_rst_count", 32'(txn_count), 32'd2);
        cmp("post_rst_rdata", 32'(last_rdata), 32'h88);

        // Saturation of the transaction counter.
        for (int i = 0; i < 130; i++)
            run_seq(NM'(i), i % 3, (i + 1) % 3, DW'(i), DW'(~i), 1'b0);
        cmp("sat_count", 32'(txn_count), 32'd255);
        run_seq(2'b01, 0, 1, 8'hEE, 8'hDD, 1'b0);
        cmp("sat_hold",  32'(txn_count), 32'd255);
        cmp("sat_led",   32'(led),       32'h0F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
